cla_adder: RTL and testbench

CLA_ADDER -- requirements
Module: cla_adder

---
 rtl/cla_adder_pkg.sv | 10 +
 rtl/cla_group4.sv | 26 ++
 rtl/cla_adder.sv | 84 ++++++++
 tb/tb_cla_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_adder_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
package cla_adder_pkg;

  // Bits handled by one first-level lookahead group.
  localparam int GROUP_W = 4;

  // Operand width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 32;

endpackage : cla_adder_pkg

// File: rtl/cla_group4.sv
// Four-bit carry-lookahead group: produces the internal carries from the
// bit-level generate/propagate terms and the group carry-in, plus the
// group generate/propagate pair consumed by the second lookahead level.
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       G,
  output logic       P
);

  // Each carry is a flat sum of products, so no carry ripples through
  // the bits of the group.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  // The group generates a carry on its own, or passes its carry-in through.
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule : cla_group4

// File: rtl/cla_adder.sv
// Registered add/subtract unit built from 4-bit lookahead groups and a
// second lookahead level across the groups; one cycle of latency.
module cla_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subEn,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             out_valid
);

  localparam int NG = WIDTH / GROUP_W;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  // Subtraction inverts b here and injects the +1 as the carry-in.
  assign b_eff = b ^ {WIDTH{subEn}};
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;

  genvar k;
  for (k = 0; k < NG; k++) begin : gen_group
    cla_group4 u_group (
      .g   (g[k*GROUP_W +: GROUP_W]),
      .p   (p[k*GROUP_W +: GROUP_W]),
      .cin (grp_c[k]),
      .c   (c[k*GROUP_W +: GROUP_W]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  // Second lookahead level: every group carry-in is a flat sum of products
  // of the group G/P pairs below it, so carries never chain group to group.
  always_comb begin
    logic term;
    logic span;
    grp_c    = '0;
    grp_c[0] = subEn;
    for (int n = 1; n <= NG; n++) begin
      term = 1'b0;
      span = 1'b1;
      for (int j = n - 1; j >= 0; j--) begin
        term = term | (span & grp_g[j]);
        span = span & grp_p[j];
      end
      grp_c[n] = term | (span & subEn);
    end
  end

  assign c[WIDTH] = grp_c[NG];
  assign sum      = p ^ c[WIDTH-1:0];

  // Output register: capture on a valid input, otherwise hold the last
  // result and drop out_valid; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= sum;
        cout   <= c[WIDTH];
      end
    end
  end

endmodule : cla_adder

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: expectations are queued when an operation
// is driven and compared one cycle later when the DUT presents it.
module tb_cla_adder;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         subEn;
  logic         in_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         out_valid;

  exp_t         sb[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] last_res;
  logic         last_co;

  cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .subEn     (subEn),
    .in_valid  (in_valid),
    .result    (result),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic; subtract carry means a >= b unsigned.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    exp_t       e;
    logic [W:0] t;
    if (s) begin
      e.res = x - y;
      e.co  = (x >= y);
    end else begin
      t     = {1'b0, x} + {1'b0, y};
      e.res = t[W-1:0];
      e.co  = t[W];
    end
    return e;
  endfunction

  // Drive one valid operation and queue what it must produce.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input exp_t e);
    a        = x;
    b        = y;
    subEn    = s;
    in_valid = 1'b1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (result !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_hold: got result=%h cout=%b ov=%b, want 0/0/0",
               result, cout, out_valid);
    else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_release_idle: got result=%h cout=%b ov=%b, want 0/0/0",
               result, cout, out_valid);
    else passes++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{32'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFF9};
    logic [W-1:0] tb [6] = '{32'd3, 32'd3, 32'd1, 32'd1,        32'd1,        32'hFFFFFFF7};
    logic         ts [6] = '{1'b0,  1'b1,  1'b1,  1'b0,         1'b0,         1'b1};
    logic [W-1:0] tr [6] = '{32'd8, 32'd2, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd2};
    logic         tc [6] = '{1'b0,  1'b1,  1'b0,  1'b1,         1'b0,         1'b1};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.res = tr[i];
      e.co  = tc[i];
      issue(ta[i], tb[i], ts[i], e);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL directed_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || result !== e.res || cout !== e.co)
          $display("[TB] FAIL directed_%0d: got result=%h cout=%b ov=%b, want %h/%b/1",
                   i, result, cout, out_valid, e.res, e.co);
        else passes++;
        last_res = e.res;
        last_co  = e.co;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    for (int i = 0; i < 32; i++) begin
      x = $urandom;
      y = $urandom;
      s = i[0];
      issue(x, y, s, model(x, y, s));
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL random_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || result !== e.res || cout !== e.co)
          $display("[TB] FAIL random_%0d: got result=%h cout=%b ov=%b, want %h/%b/1",
                   i, result, cout, out_valid, e.res, e.co);
        else passes++;
        last_res = e.res;
        last_co  = e.co;
      end
    end
  endtask

  task automatic test_idle_hold();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a     = $urandom;
      b     = $urandom;
      subEn = ~subEn;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== last_res || cout !== last_co)
        $display("[TB] FAIL idle_hold_%0d: got result=%h cout=%b ov=%b, want %h/%b/0",
                 i, result, cout, out_valid, last_res, last_co);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    a        = 32'h12345678;
    b        = 32'h11111111;
    subEn    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_midflight: got result=%h cout=%b ov=%b, want 0/0/0",
               result, cout, out_valid);
    else passes++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    e = model(32'd100, 32'd200, 1'b1);
    issue(32'd100, 32'd200, 1'b1, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL after_reset: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (out_valid !== 1'b1 || result !== e.res || cout !== e.co)
        $display("[TB] FAIL after_reset: got result=%h cout=%b ov=%b, want %h/%b/1",
                 result, cout, out_valid, e.res, e.co);
      else passes++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    subEn    = 1'b0;
    in_valid = 1'b0;
    last_res = '0;
    last_co  = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_idle_hold();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_cla_adder
